// File: rtl/muldiv_alu.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_alu
//  Brief    : RV32/64-style integer ALU with iterative M-extension unit.
//             Base ops complete in one cycle; MUL/DIV classes run XLEN
//             shift-add / restoring iterations behind a valid/ready pair.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_alu #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      alu_op,
   input  logic [2:0]      funct3,
   input  logic            funct7_5,
   input  logic            funct7_0,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int SHW = $clog2(XLEN);
   localparam int CW  = SHW + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [CW-1:0]   C_ITER = CW'(XLEN);
   localparam logic [CW-1:0]   C_ONE  = CW'(1);
   localparam logic [XLEN-1:0] C_MIN  = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]        r_state;
   logic [1:0]        w_next_state;
   logic              r_out_valid;
   logic [XLEN-1:0]   r_result;
   logic [CW-1:0]     r_count;
   logic [2*XLEN-1:0] r_prod;     // MUL: {partial, multiplier}; DIV: {remainder, quotient}
   logic [XLEN-1:0]   r_opnd;     // MUL: multiplicand magnitude; DIV: divisor magnitude
   logic              r_neg;      // negate the final value
   logic [2:0]        r_f3;

   logic              w_accept;
   logic              w_is_m, w_is_mul, w_is_div, w_div_signed;
   logic              w_div_zero, w_div_ovf, w_long;
   logic [2:0]        w_f3;
   logic              w_sub, w_arith;
   logic [SHW-1:0]    w_shamt;
   logic [XLEN-1:0]   w_sum, w_base, w_bypass, w_imm;
   logic              w_sa, w_sb;
   logic [XLEN-1:0]   w_ma, w_mb;

   logic [XLEN:0]     w_madd;
   logic [XLEN:0]     w_shift;
   logic              w_ge;
   logic [XLEN-1:0]   w_rem_new;
   logic [2*XLEN-1:0] w_step, w_prod_s;
   logic [XLEN-1:0]   w_pick, w_fin;

   assign w_accept = in_valid && in_ready;

   // Operation decode and single-cycle base ALU, including M-op bypass cases
   always_comb begin
      w_is_m       = (alu_op == 2'b00) && funct7_0;
      w_is_mul     = w_is_m && !funct3[2];
      w_is_div     = w_is_m && funct3[2];
      w_div_signed = !funct3[0];
      w_div_zero   = (b == '0);
      w_div_ovf    = w_div_signed && (a == C_MIN) && (b == '1);
      w_long       = w_is_mul || (w_is_div && !w_div_zero && !w_div_ovf);

      // load/store and branch classes collapse onto the funct3=000 adder
      w_f3    = alu_op[0] ? 3'b000 : funct3;
      w_sub   = (alu_op == 2'b11) || ((alu_op == 2'b00) && (funct3 == 3'b000) && funct7_5);
      w_arith = !alu_op[0] && funct7_5;
      w_shamt = b[SHW-1:0];
      w_sum   = w_sub ? (a - b) : (a + b);

      case (w_f3)
         3'b000:  w_base = w_sum;
         3'b001:  w_base = a << w_shamt;
         3'b010:  w_base = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         3'b011:  w_base = {{(XLEN-1){1'b0}}, (a < b)};
         3'b100:  w_base = a ^ b;
         3'b101:  w_base = w_arith ? $unsigned($signed(a) >>> w_shamt) : (a >> w_shamt);
         3'b110:  w_base = a | b;
         default: w_base = a & b;
      endcase

      if (w_div_zero)
         w_bypass = funct3[1] ? a : '1;
      else
         w_bypass = funct3[1] ? '0 : a;

      w_imm = w_is_div ? w_bypass : w_base;

      // MUL (000) low half is sign-agnostic; MULH signs both, MULHSU only a
      if (w_is_mul) begin
         w_sa = a[XLEN-1] && ((funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10));
         w_sb = b[XLEN-1] && (funct3[1:0] == 2'b01);
      end else begin
         w_sa = a[XLEN-1] && w_div_signed;
         w_sb = b[XLEN-1] && w_div_signed;
      end
      w_ma = w_sa ? (-a) : a;
      w_mb = w_sb ? (-b) : b;
   end

   // One iteration step for each long op, plus sign fix-up of the last step
   always_comb begin
      w_madd    = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_opnd} : '0);
      w_shift   = r_prod[2*XLEN-1:XLEN-1];
      w_ge      = (w_shift >= {1'b0, r_opnd});
      w_rem_new = w_ge ? (w_shift[XLEN-1:0] - r_opnd) : w_shift[XLEN-1:0];

      if (r_state == S_MUL)
         w_step = {w_madd, r_prod[XLEN-1:1]};
      else
         w_step = {w_rem_new, r_prod[XLEN-2:0], w_ge};

      w_prod_s = r_neg ? (-w_step) : w_step;
      w_pick   = r_f3[1] ? w_step[2*XLEN-1:XLEN] : w_step[XLEN-1:0];

      if (r_state == S_MUL)
         w_fin = (r_f3[1:0] == 2'b00) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
      else
         w_fin = r_neg ? (-w_pick) : w_pick;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next_state;
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept && w_long)
               w_next_state = w_is_mul ? S_MUL : S_DIV;
         end
         S_MUL, S_DIV: begin
            if (r_count == C_ONE)
               w_next_state = S_DONE;
         end
         default: begin
            if (out_ready)
               w_next_state = S_IDLE;
         end
      endcase
   end

   // Handshake outputs derived from state
   always_comb begin
      in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready);
      busy     = (r_state != S_IDLE);
   end

   // Datapath: operand capture, iteration, result and valid registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_count     <= '0;
         r_prod      <= '0;
         r_opnd      <= '0;
         r_neg       <= 1'b0;
         r_f3        <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_long) begin
                     r_out_valid <= 1'b0;
                     r_count     <= C_ITER;
                     r_f3        <= funct3;
                     if (w_is_mul) begin
                        r_prod <= {{XLEN{1'b0}}, w_mb};
                        r_opnd <= w_ma;
                        r_neg  <= w_sa ^ w_sb;
                     end else begin
                        r_prod <= {{XLEN{1'b0}}, w_ma};
                        r_opnd <= w_mb;
                        r_neg  <= funct3[1] ? w_sa : (w_sa ^ w_sb);
                     end
                  end else begin
                     r_result    <= w_imm;
                     r_out_valid <= 1'b1;
                  end
               end else if (out_ready) begin
                  r_out_valid <= 1'b0;
               end
            end
            S_MUL, S_DIV: begin
               r_prod  <= w_step;
               r_count <= r_count - C_ONE;
               if (r_count == C_ONE) begin
                  r_result    <= w_fin;
                  r_out_valid <= 1'b1;
               end
            end
            default: begin
               if (out_ready)
                  r_out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = r_out_valid;
   assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_alu
//  Brief    : Directed self-checking bench for muldiv_alu (XLEN=32).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  alu_op;
   logic [2:0]  funct3;
   logic        funct7_5;
   logic        funct7_0;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        busy;

   int tests = 0;
   int fails = 0;

   muldiv_alu #(.XLEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .funct3    (funct3),
      .funct7_5  (funct7_5),
      .funct7_0  (funct7_0),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offer one op once the DUT is ready; return cycles until out_valid and result
   task automatic run_op(input string tag, input logic [1:0] op, input logic [2:0] f3,
                         input logic f75, input logic f70, input logic [31:0] ta,
                         input logic [31:0] tbv, output int lat, output logic [31:0] res);
      int g;
      g = 0;
      while (!in_ready && g < 100) begin
         step();
         g++;
      end
      chk({tag, "_ready"}, in_ready, 1);
      alu_op = op; funct3 = f3; funct7_5 = f75; funct7_0 = f70; a = ta; b = tbv;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         step();
         lat++;
      end
      res = result;
   endtask

   task automatic vec(input string tag, input logic [1:0] op, input logic [2:0] f3,
                      input logic f75, input logic f70, input logic [31:0] ta,
                      input logic [31:0] tbv, input logic [31:0] exp, input int exp_lat);
      int lat;
      logic [31:0] res;
      run_op(tag, op, f3, f75, f70, ta, tbv, lat, res);
      chk({tag, "_res"}, res, exp);
      chk({tag, "_lat"}, lat, exp_lat);
   endtask

   initial begin
      int lat, n, busy_cnt, first_v, seen;
      logic [31:0] res;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      alu_op = 2'b00; funct3 = 3'b000; funct7_5 = 1'b0; funct7_0 = 1'b0;
      a = '0; b = '0;
      step(); step();
      rst = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);

      // Base ALU and decode corners
      vec("sub",      2'b00, 3'b000, 1, 0, 32'd5,        32'd7,        32'hFFFF_FFFE, 1);
      vec("srai",     2'b10, 3'b101, 1, 0, 32'h8000_0000, 32'd4,       32'hF800_0000, 1);
      vec("srli",     2'b10, 3'b101, 0, 0, 32'h8000_0000, 32'd4,       32'h0800_0000, 1);
      vec("sra",      2'b00, 3'b101, 1, 0, 32'h8000_0000, 32'd4,       32'hF800_0000, 1);
      vec("slt",      2'b00, 3'b010, 0, 0, 32'hFFFF_FFFF, 32'd1,       32'd1,         1);
      vec("sltu",     2'b00, 3'b011, 0, 0, 32'hFFFF_FFFF, 32'd1,       32'd0,         1);
      vec("sll_amt",  2'b00, 3'b001, 0, 0, 32'd3,        32'h21,       32'd6,         1);
      vec("add_wrap", 2'b00, 3'b000, 0, 0, 32'hFFFF_FFFF, 32'd2,       32'd1,         1);
      vec("ldst_add", 2'b01, 3'b000, 1, 1, 32'd10,       32'd3,        32'd13,        1);
      vec("br_sub",   2'b11, 3'b111, 0, 0, 32'd10,       32'd3,        32'd7,         1);
      vec("addi_f75", 2'b10, 3'b000, 1, 0, 32'd10,       32'd3,        32'd13,        1);
      vec("xori_f70", 2'b10, 3'b100, 0, 1, 32'hF0,       32'hFF,       32'h0F,        1);
      vec("slti_f75", 2'b10, 3'b010, 1, 0, 32'd1,        32'hFFFF_FFFF, 32'd0,        1);

      // M-extension iterative and bypass paths
      vec("mulh",     2'b00, 3'b001, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,        33);
      vec("mul",      2'b00, 3'b000, 0, 1, 32'd6,        32'd7,        32'd42,        33);
      vec("mulhsu",   2'b00, 3'b010, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
      vec("mulh_neg", 2'b00, 3'b001, 0, 1, 32'hFFFF_FFFE, 32'd3,       32'hFFFF_FFFF, 33);
      vec("div",      2'b00, 3'b100, 0, 1, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD, 33);
      vec("rem",      2'b00, 3'b110, 0, 1, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 33);
      vec("div_nb",   2'b00, 3'b100, 0, 1, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
      vec("rem_nb",   2'b00, 3'b110, 0, 1, 32'd7,        32'hFFFF_FFFE, 32'd1,        33);
      vec("divu",     2'b00, 3'b101, 0, 1, 32'd100,      32'd7,        32'd14,        33);
      vec("remu",     2'b00, 3'b111, 0, 1, 32'd100,      32'd7,        32'd2,         33);
      vec("divu_z",   2'b00, 3'b101, 0, 1, 32'h1234,     32'd0,        32'hFFFF_FFFF, 1);
      vec("remu_z",   2'b00, 3'b111, 0, 1, 32'h1234,     32'd0,        32'h1234,      1);
      vec("div_ovf",  2'b00, 3'b100, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      vec("rem_ovf",  2'b00, 3'b110, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        1);

      // MULHU with busy window tracked cycle by cycle
      step();
      chk("mulhu_ready", in_ready, 1);
      alu_op = 2'b00; funct3 = 3'b011; funct7_5 = 0; funct7_0 = 1;
      a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      busy_cnt = 0; first_v = 0; res = '0;
      for (int c = 1; c <= 40; c++) begin
         if (busy) busy_cnt++;
         if (out_valid && first_v == 0) begin
            first_v = c;
            res = result;
         end
         step();
      end
      chk("mulhu_res", res, 32'hFFFF_FFFE);
      chk("mulhu_valid_cycle", first_v, 33);
      chk("mulhu_busy_cycles", busy_cnt, 33);
      chk("mulhu_busy_after", busy, 0);

      // Back-pressure on a base op: result frozen, in_ready low
      out_ready = 1'b0;
      run_op("bp_add", 2'b00, 3'b000, 0, 0, 32'd20, 32'd22, lat, res);
      chk("bp_add_res", res, 32'd42);
      for (int c = 0; c < 3; c++) begin
         alu_op = 2'b00; funct3 = 3'b100; a = 32'hAAAA; b = 32'h5555;
         in_valid = 1'b1;
         step();
         chk("bp_add_hold", result, 32'd42);
         chk("bp_add_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      chk("bp_add_drain", out_valid, 0);

      // Back-pressure after a long op, inputs disturbed mid-iteration
      out_ready = 1'b0;
      alu_op = 2'b00; funct3 = 3'b000; funct7_5 = 0; funct7_0 = 1;
      a = 32'd6; b = 32'd7;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int c = 0; c < 4; c++) step();
      a = 32'd1000; b = 32'd3; funct3 = 3'b100;
      in_valid = 1'b1;
      step(); step(); step();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         step();
         n++;
      end
      chk("hold_first", result, 32'd42);
      for (int c = 0; c < 5; c++) begin
         in_valid = c[0];
         alu_op = 2'b00; funct3 = 3'b000; funct7_0 = 0; a = 32'd1; b = 32'd1;
         step();
         chk("hold_res", result, 32'd42);
         chk("hold_in_ready", in_ready, 0);
         chk("hold_valid", out_valid, 1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      chk("hold_release_valid", out_valid, 0);
      chk("hold_release_busy", busy, 0);
      chk("hold_release_ready", in_ready, 1);

      // Reset in the middle of a DIVU
      alu_op = 2'b00; funct3 = 3'b101; funct7_5 = 0; funct7_0 = 1;
      a = 32'd100; b = 32'd7;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int c = 1; c < 10; c++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_valid", out_valid, 0);
      chk("abort_ready", in_ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_result", result, 0);
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         if (out_valid) seen++;
         step();
      end
      chk("abort_no_result", seen, 0);
      vec("post_abort_add", 2'b00, 3'b000, 0, 0, 32'd2, 32'd3, 32'd5, 1);

      // Reset wins over a simultaneous acceptance
      step();
      alu_op = 2'b00; funct3 = 3'b000; funct7_5 = 0; funct7_0 = 0;
      a = 32'd9; b = 32'd9;
      in_valid = 1'b1;
      rst = 1'b1;
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      chk("rst_prio_valid", out_valid, 0);
      chk("rst_prio_result", result, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
